// File: rtl/sequence_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam logic [7:0]  DEFAULT_PATTERN  = 8'b0111_0001;
    localparam logic        DEFAULT_IDLE_BIT = 1'b1;

endpackage

// File: rtl/sequence_gen_if.sv
// Request/serial-output bundle of sequence_gen; the generator is the slave side.
interface sequence_gen_if #(
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP_W = 4
);
    logic             start;
    logic [REP_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             stop;
    logic             a;
    logic             valid;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, repeat_n, gap, stop,
        input  a, valid, frame_start, busy, done
    );

    modport slave (
        input  start, repeat_n, gap, stop,
        output a, valid, frame_start, busy, done
    );
endinterface

// File: rtl/sequence_gen_shifter.sv
// Parallel-load shift register holding the pattern plus the index of the bit on the line.
module seq_gen_shifter
    import seq_gen_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift,
    output logic next_bit,
    output logic last
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        sr_d  = sr_q;
        idx_d = idx_q;
        if (load) begin
            sr_d  = PATTERN;
            idx_d = IDX_W'(WIDTH - 1);
        end else if (shift) begin
            sr_d  = sr_q << 1;
            idx_d = idx_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    // sr_q[WIDTH-1] is the bit currently on the line; the one below it goes out next.
    assign next_bit = sr_q[WIDTH-2];
    assign last     = (idx_q == '0);

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern generator: emits PATTERN MSB first, optionally repeated with idle gaps.
module sequence_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] PATTERN  = DEFAULT_PATTERN,
    parameter int unsigned      REP_W    = 4,
    parameter int unsigned      GAP_W    = 4,
    parameter logic             IDLE_BIT = DEFAULT_IDLE_BIT
) (
    input  logic          clk,
    input  logic          rst,
    sequence_gen_if.slave bus
);
    state_e           state_q, state_d;
    logic [REP_W-1:0] copies_q, copies_d;
    logic [GAP_W-1:0] gap_l_q, gap_l_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             stop_pend_q, stop_pend_d;
    logic             a_q, a_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic sh_load, sh_shift, sh_next_bit, sh_last;
    logic stop_now;

    seq_gen_shifter #(
        .WIDTH  (WIDTH),
        .PATTERN(PATTERN)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .shift   (sh_shift),
        .next_bit(sh_next_bit),
        .last    (sh_last)
    );

    // A stop sampled on the deciding edge counts as well as one already pending.
    assign stop_now = stop_pend_q | bus.stop;

    always_comb begin
        state_d     = state_q;
        copies_d    = copies_q;
        gap_l_d     = gap_l_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        a_d         = IDLE_BIT;
        valid_d     = 1'b0;
        fs_d        = 1'b0;
        done_d      = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;

        unique case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (bus.start) begin
                    state_d  = SHIFT;
                    sh_load  = 1'b1;
                    copies_d = (bus.repeat_n == '0) ? '0 : bus.repeat_n - REP_W'(1);
                    gap_l_d  = bus.gap;
                    a_d      = PATTERN[WIDTH-1];
                    valid_d  = 1'b1;
                    fs_d     = 1'b1;
                end
            end
            SHIFT: begin
                stop_pend_d = stop_now;
                if (!sh_last) begin
                    sh_shift = 1'b1;
                    a_d      = sh_next_bit;
                    valid_d  = 1'b1;
                end else if (copies_q == '0 || stop_now) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_l_q == '0) begin
                    sh_load  = 1'b1;
                    copies_d = copies_q - REP_W'(1);
                    a_d      = PATTERN[WIDTH-1];
                    valid_d  = 1'b1;
                    fs_d     = 1'b1;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = gap_l_q;
                end
            end
            GAP: begin
                stop_pend_d = stop_now;
                if (stop_now) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d  = SHIFT;
                    sh_load  = 1'b1;
                    copies_d = copies_q - REP_W'(1);
                    a_d      = PATTERN[WIDTH-1];
                    valid_d  = 1'b1;
                    fs_d     = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            copies_q    <= '0;
            gap_l_q     <= '0;
            gap_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            a_q         <= IDLE_BIT;
            valid_q     <= 1'b0;
            fs_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            copies_q    <= copies_d;
            gap_l_q     <= gap_l_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            a_q         <= a_d;
            valid_q     <= valid_d;
            fs_q        <= fs_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.a           = a_q;
    assign bus.valid       = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
